// File: rtl/mic_buf_pkg.sv
// Shared types and constants for the microphone sample buffer.
package mic_buf_pkg;

    // One captured microphone word.
    typedef logic [15:0] sample_t;

    // Width of the saturating missed-tick counter.
    localparam int unsigned MISSED_W = 8;

    // Capture engine states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_BUSY    = 3'd4,
        ST_STORE   = 3'd5
    } mic_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
        if (v == {MISSED_W{1'b1}}) begin
            return v;
        end else begin
            return v + MISSED_W'(1);
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular first-word-fall-through FIFO. The head word is kept in a register
// that is computed one cycle ahead, so rd_data_o and rd_valid_o are flops.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_ready_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     wr_accept_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full_s;
    logic             rd_fire_s;
    logic             wr_accept_s;

    // Handshake decode, pointer/level next state and look-ahead head word.
    always_comb begin
        full_s      = (level_q == LVL_W'(DEPTH));
        rd_fire_s   = rd_valid_q && rd_ready_i;
        // A full FIFO still takes a write when a word leaves in the same cycle.
        wr_accept_s = wr_en_i && (!full_s || rd_fire_s);

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_accept_s, rd_fire_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        rd_valid_d = (level_d != LVL_W'(0));

        // The next head is either an already stored word or the word being
        // written right now into the slot the read pointer is about to point at.
        if (rd_valid_d) begin
            if (wr_accept_s && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Pointer, occupancy and head-word registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_accept_s && !rst_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign level_o     = level_q;
    assign full_o      = full_s;
    assign wr_accept_o = wr_accept_s;

endmodule

// File: rtl/mic_sample_buffer.sv
// Periodic SPI microphone sampler: issues the start strobe, waits for the
// chip-select cycle, captures the word and queues it in a FWFT FIFO.
module mic_sample_buffer
    import mic_buf_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 3125,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    sample,
    input  logic                    spi_cs_b,
    input  logic [15:0]             spi_data,
    output logic [15:0]             rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    timeout_err,
    input  logic                    clr_flags,
    output logic [MISSED_W-1:0]     missed
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    mic_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    sample_t             data_q, data_d;
    logic                sample_q, sample_d;
    logic                overflow_q, overflow_d;
    logic                timeout_err_q, timeout_err_d;
    logic [MISSED_W-1:0] missed_q, missed_d;

    logic                tick_s;
    logic                tmo_fire_s;
    logic                wr_en_s;
    logic                wr_accept_s;
    logic                full_s;
    logic                ovf_set_s;

    // Sample period counter; tick on terminal count, parked at zero when disabled.
    always_comb begin
        tick_s = enable && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        if (!enable) begin
            cnt_d = '0;
        end else if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Capture engine next state, timeout counter and captured word.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        tmo_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!spi_cs_b) begin
                    state_d = ST_BUSY;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_fire_s = 1'b1;
                    state_d    = ST_ARM;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_BUSY: begin
                // spi_data is final on the first cycle chip-select is back high.
                if (spi_cs_b) begin
                    data_d  = spi_data;
                    state_d = ST_STORE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_STORE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sample_d = (state_d == ST_ISSUE);
    end

    // Sticky flags (set beats clear) and the saturating missed-tick counter.
    always_comb begin
        wr_en_s   = (state_q == ST_STORE);
        ovf_set_s = wr_en_s && full_s && !wr_accept_s;

        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (tmo_fire_s) begin
            timeout_err_d = 1'b1;
        end else if (clr_flags) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        // A tick outside ARM is dropped, not queued.
        if (tick_s && (state_q != ST_ARM)) begin
            missed_d = sat_inc(missed_q);
        end else begin
            missed_d = missed_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tmo_q         <= '0;
            data_q        <= '0;
            sample_q      <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            missed_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            data_q        <= data_d;
            sample_q      <= sample_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            missed_q      <= missed_d;
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (sysclk),
        .rst_i       (reset),
        .wr_en_i     (wr_en_s),
        .wr_data_i   (data_q),
        .rd_ready_i  (rd_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .level_o     (level),
        .full_o      (full_s),
        .wr_accept_o (wr_accept_s)
    );

    assign sample      = sample_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign missed      = missed_q;

endmodule

// File: tb/tb_mic_sample_buffer.sv
// Randomized bench for mic_sample_buffer. A transaction-level reference keeps
// the FIFO as a queue and predicts strobes, drops and flags from a schedule of
// SPI responses that the bench itself chooses when each strobe is predicted.
module tb_mic_sample_buffer;

    localparam int DIV   = 20;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        sysclk = 1'b0;
    logic        reset, enable, spi_cs_b, rd_ready, clr_flags;
    logic [15:0] spi_data;
    logic        sample, rd_valid, overflow, timeout_err;
    logic [15:0] rd_data;
    logic [2:0]  level;
    logic [7:0]  missed;

    mic_sample_buffer #(.SAMPLE_DIV(DIV), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .enable      (enable),
        .sample      (sample),
        .spi_cs_b    (spi_cs_b),
        .spi_data    (spi_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_flags   (clr_flags),
        .missed      (missed)
    );

    always #5 sysclk = ~sysclk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference state
    logic [15:0] mq[$];
    bit          m_ovf, m_tmo, just_rst, did_rst;
    int          m_missed, m_phase, free_at;
    int          s_cyc, lo_s, lo_e, c_cyc, store_cyc, tmo_cyc;
    logic [15:0] d_word;

    typedef struct {
        int ncyc;
        int rd_mode;   // 0 random, 1 never, 2 only in store cycles, 3 always
        int tmo_pct;
        bit en_tog;
        int clr_pct;
        bit rst_busy;
    } phase_t;
    phase_t ph[8];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_ovf = 1'b0; m_tmo = 1'b0; m_missed = 0; m_phase = 0; free_at = 0;
        s_cyc = -1; lo_s = -1; lo_e = -1; c_cyc = -1; store_cyc = -1; tmo_cyc = -1;
    endtask

    // Decide how the SPI stage answers a strobe issued in cycle s.
    task automatic schedule(input int s, input int tmo_pct);
        int d, len;
        s_cyc = s;
        if (int'($urandom_range(0, 99)) < tmo_pct) begin
            lo_s = -1; lo_e = -1; c_cyc = -1; store_cyc = -1;
            tmo_cyc = s + TMO;
            free_at = s + TMO + 1;
        end else begin
            d         = ($urandom_range(0, 4) == 0) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
            len       = int'($urandom_range(1, 2 * DIV));
            lo_s      = s + 1 + d;
            lo_e      = lo_s + len - 1;
            c_cyc     = lo_e + 1;
            store_cyc = c_cyc + 1;
            free_at   = c_cyc + 2;
            tmo_cyc   = -1;
            d_word    = 16'($urandom);
        end
    endtask

    task automatic compare_all();
        check_val("sample", 32'(sample), 32'(cyc == s_cyc));
        check_val("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
        check_val("level", 32'(level), 32'(mq.size()));
        if (mq.size() > 0) check_val("rd_data", 32'(rd_data), 32'(mq[0]));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("timeout_err", 32'(timeout_err), 32'(m_tmo));
        check_val("missed", 32'(missed), 32'(m_missed));
        if (just_rst) begin
            check_val("rd_data_rst", 32'(rd_data), 32'h0);
            just_rst = 1'b0;
        end
    endtask

    task automatic drive(input int p, input int n);
        reset = 1'b0;
        if (ph[p].rst_busy && !did_rst && mq.size() == 2 && lo_s >= 0 && cyc > lo_s && cyc <= lo_e) begin
            reset   = 1'b1;
            did_rst = 1'b1;
        end
        if (ph[p].en_tog) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
        end else begin
            enable = 1'b1;
        end
        clr_flags = (n == 0) || (int'($urandom_range(0, 99)) < ph[p].clr_pct);
        case (ph[p].rd_mode)
            0:       rd_ready = 1'($urandom_range(0, 1));
            1:       rd_ready = 1'b0;
            2:       rd_ready = (cyc == store_cyc);
            default: rd_ready = 1'b1;
        endcase
        spi_cs_b = !(lo_s >= 0 && cyc >= lo_s && cyc <= lo_e);
        spi_data = (c_cyc >= 0 && cyc >= c_cyc) ? d_word : 16'($urandom);
    endtask

    // Advance the reference by one clock using this cycle's inputs.
    task automatic step(input int p);
        bit tick, rd_en, acc, set_ovf, set_tmo;
        if (reset) begin
            m_reset();
            just_rst = 1'b1;
        end else begin
            tick    = enable && (m_phase == DIV - 1);
            m_phase = enable ? ((m_phase == DIV - 1) ? 0 : m_phase + 1) : 0;
            rd_en   = (mq.size() > 0) && rd_ready;
            acc     = 1'b0;
            set_ovf = 1'b0;
            set_tmo = (cyc == tmo_cyc);
            if (cyc == store_cyc) begin
                if (mq.size() < DEPTH || rd_en) acc = 1'b1;
                else set_ovf = 1'b1;
            end
            if (rd_en) void'(mq.pop_front());
            if (acc) mq.push_back(d_word);
            if (set_ovf) m_ovf = 1'b1;
            else if (clr_flags) m_ovf = 1'b0;
            if (set_tmo) m_tmo = 1'b1;
            else if (clr_flags) m_tmo = 1'b0;
            if (tick) begin
                if (cyc >= free_at) schedule(cyc + 1, ph[p].tmo_pct);
                else if (m_missed < 255) m_missed++;
            end
        end
    endtask

    initial begin
        ph[0] = '{200,  3, 0,   1'b0, 0, 1'b0};  // basic capture, reader always ready
        ph[1] = '{400,  1, 0,   1'b0, 0, 1'b0};  // fill and overflow
        ph[2] = '{400,  2, 0,   1'b0, 0, 1'b0};  // full with read in the store cycle
        ph[3] = '{100,  3, 0,   1'b0, 0, 1'b0};  // drain
        ph[4] = '{400,  0, 100, 1'b0, 3, 1'b0};  // no response, timeouts
        ph[5] = '{600,  1, 0,   1'b0, 0, 1'b1};  // reset mid-transfer with two words stored
        ph[6] = '{3000, 0, 20,  1'b1, 2, 1'b0};  // random with enable toggling
        ph[7] = '{1500, 0, 10,  1'b0, 1, 1'b0};  // random steady

        reset = 1'b1; enable = 1'b0; spi_cs_b = 1'b1; spi_data = 16'h0;
        rd_ready = 1'b0; clr_flags = 1'b0;
        d_word = 16'h0; did_rst = 1'b0; just_rst = 1'b1;
        m_reset();
        @(negedge sysclk);
        for (int p = 0; p < 8; p++) begin
            for (int n = 0; n < ph[p].ncyc; n++) begin
                compare_all();
                drive(p, n);
                step(p);
                cyc++;
                @(negedge sysclk);
            end
        end
        compare_all();
        if (!did_rst) check_val("reset_busy_reached", 32'(did_rst), 32'h1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
